// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store alignment unit.
// Holds funct3 encodings, FSM states and access-size/legality functions.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    BUS0,
    WAIT0,
    BUS1,
    WAIT1,
    RESP
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] f);
    return 4'd1 << f[1:0];
  endfunction

  function automatic logic legal(input logic [2:0] f,
                                 input logic we,
                                 input int xlen);
    logic w64;
    w64 = (xlen == 64);
    if (we)
      return (f == SB) || (f == SH) || (f == SW) ||
             ((f == SD) && w64);
    return (f == LB) || (f == LH) || (f == LW) ||
           (f == LBU) || (f == LHU) ||
           ((f == LD) && w64) || ((f == LWU) && w64);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of a right-justified load value.
// Size comes from funct3[1:0], signedness from funct3[2].
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  logic [XLEN-1:0] mask;
  logic            msb;
  logic            fill;

  // keep the low size bytes, replicate the top kept bit when signed
  always_comb begin
    mask = '1;
    msb  = din[XLEN-1];
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        mask = XLEN'(8'hff);
        msb  = din[7];
      end
      funct3[1:0] == 2'b01: begin
        mask = XLEN'(16'hffff);
        msb  = din[15];
      end
      funct3[1:0] == 2'b10: begin
        mask = XLEN'(32'hffff_ffff);
        msb  = din[31];
      end
      default: ;
    endcase
    fill = msb & ~funct3[2];
    dout = (din & mask) | (~mask & {XLEN{fill}});
  end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: splits/aligns core loads and stores onto a word-wide bus.
// Crossing accesses take two beats; loads are reassembled and extended.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_fault
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  state_t state;

  logic [OB-1:0]     off_in;
  logic [3:0]        sz_in;
  logic [2*NB-1:0]   lanes;
  logic [2*NB-1:0]   be_in;
  logic [2*XLEN-1:0] wd_in;
  logic [31:0]       base_in;
  logic              cross_in;
  logic              bad_in;

  assign off_in   = req_addr[OB-1:0];
  assign sz_in    = size_bytes(req_funct3);
  assign lanes    = ((2*NB)'(1) << sz_in) - (2*NB)'(1);
  assign be_in    = lanes << off_in;
  assign cross_in = |be_in[2*NB-1:NB];
  assign wd_in    = {{XLEN{1'b0}}, req_wdata} << {off_in, 3'b000};
  assign base_in  = {req_addr[31:OB], {OB{1'b0}}};
  assign bad_in   = !legal(req_funct3, req_we, XLEN) ||
                    (cross_in && !ALLOW_SPLIT);

  logic              r_we;
  logic [2:0]        r_f3;
  logic [OB-1:0]     r_off;
  logic              r_cross;
  logic [NB-1:0]     r_be1;
  logic [XLEN-1:0]   r_wd1;
  logic [31:0]       r_addr1;
  logic [XLEN-1:0]   rbuf;

  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   ext;

  assign lo  = (state == WAIT1) ? rbuf : mem_rdata;
  assign raw = XLEN'({mem_rdata, lo} >> {r_off, 3'b000});

  lsu_extend #(.XLEN(XLEN)) u_ext (
    .funct3 (r_f3),
    .din    (raw),
    .dout   (ext)
  );

  // access sequencer with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_off     <= '0;
      r_cross   <= 1'b0;
      r_be1     <= '0;
      r_wd1     <= '0;
      r_addr1   <= '0;
      rbuf      <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          r_we      <= req_we;
          r_f3      <= req_funct3;
          r_off     <= off_in;
          r_cross   <= cross_in;
          r_be1     <= be_in[2*NB-1:NB];
          r_wd1     <= wd_in[2*XLEN-1:XLEN];
          r_addr1   <= base_in + 32'(NB);
          if (bad_in) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_data  <= '0;
          end else begin
            state     <= BUS0;
            mem_valid <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= base_in;
            mem_be    <= be_in[NB-1:0];
            mem_wdata <= req_we ? wd_in[XLEN-1:0] : '0;
          end
        end
        BUS0: if (mem_ready) begin
          mem_valid <= 1'b0;
          state     <= WAIT0;
        end
        WAIT0: if (mem_rvalid) begin
          if (r_cross) begin
            rbuf      <= mem_rdata;
            state     <= BUS1;
            mem_valid <= 1'b1;
            mem_addr  <= r_addr1;
            mem_be    <= r_be1;
            mem_wdata <= r_we ? r_wd1 : '0;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_data  <= r_we ? '0 : ext;
          end
        end
        BUS1: if (mem_ready) begin
          mem_valid <= 1'b0;
          state     <= WAIT1;
        end
        WAIT1: if (mem_rvalid) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_data  <= r_we ? '0 : ext;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed and randomized checks of lsu_align (XLEN=32).
// Byte-addressed memory reference model; second instance without split.
module tb_lsu_align;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid, rsp_valid, rsp_fault;
  logic [31:0] rsp_data;

  logic        n_req_valid, n_req_ready, n_req_we;
  logic [2:0]  n_req_funct3;
  logic [31:0] n_req_addr, n_req_wdata;
  logic        n_mem_valid, n_mem_ready, n_mem_we;
  logic [31:0] n_mem_addr, n_mem_wdata, n_mem_rdata;
  logic [3:0]  n_mem_be;
  logic        n_mem_rvalid, n_rsp_valid, n_rsp_fault;
  logic [31:0] n_rsp_data;

  always #5 clk = ~clk;

  lsu_align #(.XLEN(32), .ALLOW_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
  );

  lsu_align #(.XLEN(32), .ALLOW_SPLIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
    .req_funct3(n_req_funct3), .req_addr(n_req_addr),
    .req_wdata(n_req_wdata),
    .mem_valid(n_mem_valid), .mem_ready(n_mem_ready), .mem_we(n_mem_we),
    .mem_addr(n_mem_addr), .mem_be(n_mem_be), .mem_wdata(n_mem_wdata),
    .mem_rvalid(n_mem_rvalid), .mem_rdata(n_mem_rdata),
    .rsp_valid(n_rsp_valid), .rsp_data(n_rsp_data),
    .rsp_fault(n_rsp_fault)
  );

  int tests = 0;
  int fails = 0;

  bit [7:0] bmem [0:511];
  bit [7:0] rmem [0:511];

  int          nbeats, rsp_cyc;
  logic [31:0] b_addr [2];
  logic [31:0] b_wd [2];
  logic [3:0]  b_be [2];
  logic        b_we [2];
  logic        got_rsp, got_fault, rdy0, post_v, post_r;
  logic [31:0] got_data;
  bit          unstable;

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int l = 0; l < 4; l++) begin
      bmem[9'(a + 32'(l))] = w[8*l +: 8];
      rmem[9'(a + 32'(l))] = w[8*l +: 8];
    end
  endtask

  // one request plus a bus responder; results land in the b_*/got_* vars
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input bit st);
    int cnt;
    bit inb;
    logic [31:0] aa, aw;
    logic [3:0] ab;
    logic ae;
    nbeats = 0; got_rsp = 0; rsp_cyc = -1; unstable = 0;
    got_data = '0; got_fault = 0;
    cnt = 0; inb = 0; aa = '0; aw = '0; ab = '0; ae = 0;
    rdy0 = req_ready;
    req_valid = 1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c < 60 && !got_rsp; c++) begin
      mem_rvalid = 0; mem_ready = 0; mem_rdata = $urandom;
      if (rsp_valid) begin
        got_rsp = 1; rsp_cyc = c;
        got_data = rsp_data; got_fault = rsp_fault;
        if (st) mem_rvalid = 1;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mem_rvalid = 1;
            for (int l = 0; l < 4; l++) begin
              if (ae && ab[l]) bmem[9'(aa + 32'(l))] = aw[8*l +: 8];
              mem_rdata[8*l +: 8] = bmem[9'(aa + 32'(l))];
            end
          end
        end
        if (mem_valid) begin
          if (!inb) begin
            if (nbeats < 2) begin
              b_addr[nbeats] = mem_addr; b_be[nbeats] = mem_be;
              b_wd[nbeats] = mem_wdata; b_we[nbeats] = mem_we;
            end
            nbeats++; inb = 1;
            aa = mem_addr; ab = mem_be; aw = mem_wdata; ae = mem_we;
          end else if ({mem_addr, mem_be, mem_wdata, mem_we} !==
                       {aa, ab, aw, ae}) begin
            unstable = 1;
          end
          if (st && $urandom_range(0, 2) == 0) begin
            mem_rvalid = 1'($urandom);
          end else begin
            mem_ready = 1; inb = 0;
            cnt = st ? $urandom_range(1, 3) : 1;
          end
        end
      end
      if (!got_rsp) begin
        @(posedge clk); #1;
      end
    end
    mem_rvalid = 0; mem_ready = 0;
    @(posedge clk); #1;
    post_v = rsp_valid; post_r = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 0;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    n_req_valid = 0; n_req_we = 0; n_req_funct3 = 0; n_req_addr = 0;
    n_req_wdata = 0; n_mem_ready = 0; n_mem_rvalid = 0; n_mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    tests++;
    if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
         rsp_valid, rsp_data, rsp_fault} !== 104'd0) begin
      fails++;
      $display("FAIL reset_outs: mv=%b we=%b a=%h be=%b wd=%h rv=%b rd=%h rf=%b want all 0",
               mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_data, rsp_fault);
    end
    tests++;
    if ({n_req_ready, n_mem_valid, n_rsp_valid, n_rsp_fault} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_nosplit: got %b want 1000",
               {n_req_ready, n_mem_valid, n_rsp_valid, n_rsp_fault});
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_lb();
    set_word(32'h100, 32'h80FF_1234);
    run_access(0, LB, 32'h103, 32'hDEAD_BEEF, 0);
    tests++;
    if ({nbeats, b_addr[0], b_be[0], b_we[0], b_wd[0]} !==
        {32'd1, 32'h100, 4'b1000, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL lb_beat: n=%0d a=%h be=%b we=%b wd=%h want 1 100 1000 0 0",
               nbeats, b_addr[0], b_be[0], b_we[0], b_wd[0]);
    end
    tests++;
    if (got_data !== 32'hFFFF_FF80 || got_fault !== 1'b0) begin
      fails++;
      $display("FAIL lb_data: got %h f=%b want ffffff80 f=0", got_data, got_fault);
    end
    tests++;
    if (rsp_cyc != 3) begin
      fails++; $display("FAIL lb_latency: got %0d want 3", rsp_cyc);
    end
  endtask

  task automatic test_half();
    set_word(32'h100, 32'hBEEF_0000);
    run_access(0, LHU, 32'h102, 32'h0, 0);
    tests++;
    if (b_be[0] !== 4'b1100 || got_data !== 32'h0000_BEEF) begin
      fails++;
      $display("FAIL lhu: be=%b data=%h want 1100 0000beef", b_be[0], got_data);
    end
    set_word(32'h100, 32'h00AB_CD00);
    run_access(0, LH, 32'h101, 32'h0, 0);
    tests++;
    if (nbeats != 1 || b_be[0] !== 4'b0110 || got_data !== 32'hFFFF_ABCD) begin
      fails++;
      $display("FAIL lh_unaligned: n=%0d be=%b data=%h want 1 0110 ffffabcd",
               nbeats, b_be[0], got_data);
    end
  endtask

  task automatic test_split_load();
    set_word(32'h0FC, 32'hAABB_CCDD);
    set_word(32'h100, 32'h1122_3344);
    run_access(0, LW, 32'h0FE, 32'h0, 0);
    tests++;
    if ({nbeats, b_addr[0], b_be[0], b_addr[1], b_be[1]} !==
        {32'd2, 32'h0FC, 4'b1100, 32'h100, 4'b0011}) begin
      fails++;
      $display("FAIL split_ld_beats: n=%0d %h/%b %h/%b want 2 fc/1100 100/0011",
               nbeats, b_addr[0], b_be[0], b_addr[1], b_be[1]);
    end
    tests++;
    if (got_data !== 32'h3344_AABB || rsp_cyc != 5) begin
      fails++;
      $display("FAIL split_ld_data: got %h cyc %0d want 3344aabb cyc 5",
               got_data, rsp_cyc);
    end
  endtask

  task automatic test_split_store();
    run_access(1, SH, 32'h0FF, 32'h0000_1234, 0);
    tests++;
    if ({nbeats, b_addr[0], b_be[0], b_wd[0], b_we[0]} !==
        {32'd2, 32'h0FC, 4'b1000, 32'h3400_0000, 1'b1}) begin
      fails++;
      $display("FAIL sh_beat0: n=%0d a=%h be=%b wd=%h we=%b want 2 fc 1000 34000000 1",
               nbeats, b_addr[0], b_be[0], b_wd[0], b_we[0]);
    end
    tests++;
    if ({b_addr[1], b_be[1], b_wd[1], b_we[1]} !==
        {32'h100, 4'b0001, 32'h0000_0012, 1'b1}) begin
      fails++;
      $display("FAIL sh_beat1: a=%h be=%b wd=%h we=%b want 100 0001 00000012 1",
               b_addr[1], b_be[1], b_wd[1], b_we[1]);
    end
    tests++;
    if (got_data !== 32'h0 || got_fault !== 1'b0 ||
        bmem[9'h0FF] !== 8'h34 || bmem[9'h100] !== 8'h12) begin
      fails++;
      $display("FAIL sh_result: data=%h f=%b mem=%h %h want 0 0 34 12",
               got_data, got_fault, bmem[9'h0FF], bmem[9'h100]);
    end
  endtask

  task automatic test_faults();
    run_access(0, LD, 32'h100, 32'h0, 0);
    tests++;
    if (got_fault !== 1'b1 || rsp_cyc != 1 || nbeats != 0 || got_data !== 0) begin
      fails++;
      $display("FAIL ld_fault: f=%b cyc=%0d n=%0d d=%h want 1 1 0 0",
               got_fault, rsp_cyc, nbeats, got_data);
    end
    run_access(1, 3'b100, 32'h100, 32'h55, 0);
    tests++;
    if (got_fault !== 1'b1 || nbeats != 0) begin
      fails++;
      $display("FAIL st_fault: f=%b n=%0d want 1 0", got_fault, nbeats);
    end
    n_req_valid = 1; n_req_we = 0; n_req_funct3 = LW;
    n_req_addr = 32'h0FE; n_req_wdata = 0;
    @(posedge clk); #1;
    n_req_valid = 0;
    tests++;
    if ({n_rsp_valid, n_rsp_fault, n_mem_valid, n_rsp_data} !==
        {3'b110, 32'h0}) begin
      fails++;
      $display("FAIL nosplit_fault: rv=%b f=%b mv=%b d=%h want 1 1 0 0",
               n_rsp_valid, n_rsp_fault, n_mem_valid, n_rsp_data);
    end
    @(posedge clk); #1;
    tests++;
    if ({n_rsp_valid, n_mem_valid, n_req_ready} !== 3'b001) begin
      fails++;
      $display("FAIL nosplit_after: got %b want 001",
               {n_rsp_valid, n_mem_valid, n_req_ready});
    end
    n_req_valid = 1; n_req_addr = 32'h100;
    @(posedge clk); #1;
    n_req_valid = 0;
    tests++;
    if ({n_mem_valid, n_rsp_valid, n_mem_be} !== 6'b10_1111) begin
      fails++;
      $display("FAIL nosplit_aligned_bus: got %b want 101111",
               {n_mem_valid, n_rsp_valid, n_mem_be});
    end
    n_mem_ready = 1;
    @(posedge clk); #1;
    n_mem_ready = 0; n_mem_rvalid = 1; n_mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    n_mem_rvalid = 0;
    tests++;
    if ({n_rsp_valid, n_rsp_fault, n_rsp_data} !== {2'b10, 32'h1234_5678}) begin
      fails++;
      $display("FAIL nosplit_aligned_rsp: rv=%b f=%b d=%h want 1 0 12345678",
               n_rsp_valid, n_rsp_fault, n_rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    req_valid = 1; req_we = 0; req_funct3 = LW; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 0; mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    tests++;
    if ({req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
         rsp_valid, rsp_data, rsp_fault} !== {1'b1, 104'd0}) begin
      fails++;
      $display("FAIL midop_reset: rdy=%b mv=%b a=%h be=%b rv=%b rd=%h want reset values",
               req_ready, mem_valid, mem_addr, mem_be, rsp_valid, rsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1; mem_rdata = $urandom;
      @(posedge clk); #1;
      tests++;
      if ({rsp_valid, mem_valid, req_ready} !== 3'b001) begin
        fails++;
        $display("FAIL midop_stray_rvalid: got %b want 001",
                 {rsp_valid, mem_valid, req_ready});
      end
    end
    mem_rvalid = 0;
  endtask

  task automatic test_random();
    logic [2:0] lf [5] = '{LB, LH, LW, LBU, LHU};
    rmem = bmem;
    for (int n = 0; n < 200; n++) begin
      logic we, lg, cr;
      logic [2:0] f3;
      logic [31:0] a, wd, exp, w0, w1;
      logic [3:0] be0, be1;
      logic [63:0] wsh;
      longint v;
      int sz, off, bad;
      bit st;
      we = 1'($urandom);
      f3 = (n % 10 == 9) ? 3'($urandom) : lf[$urandom_range(0, we ? 2 : 4)];
      a = $urandom_range(0, 32'h1F0);
      wd = $urandom;
      st = 1'($urandom);
      lg = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == LBU || f3 == LHU);
      sz = 1 << f3[1:0];
      off = int'(a[1:0]);
      cr = (off + sz > 4);
      v = 0;
      for (int i = 0; i < sz; i++)
        v += longint'(rmem[9'(a + 32'(i))]) << (8 * i);
      if (!f3[2] && ((v >> (8 * sz - 1)) & 1) == 1)
        v -= longint'(1) << (8 * sz);
      exp = (we || !lg) ? 32'h0 : 32'(v);
      be0 = 0; be1 = 0;
      for (int i = 0; i < sz; i++)
        if (off + i < 4) be0 |= 4'(1 << (off + i));
        else be1 |= 4'(1 << (off + i - 4));
      wsh = 64'(wd) << (8 * off);
      w0 = we ? wsh[31:0] : 32'h0;
      w1 = we ? wsh[63:32] : 32'h0;
      run_access(we, f3, a, wd, st);
      tests++;
      if (!got_rsp || got_fault !== !lg || got_data !== exp) begin
        fails++;
        $display("FAIL rand_rsp[%0d]: we=%b f3=%b a=%h rsp=%b f=%b d=%h want f=%b d=%h",
                 n, we, f3, a, got_rsp, got_fault, got_data, !lg, exp);
      end
      tests++;
      if (rdy0 !== 1'b1 || post_v !== 1'b0 || post_r !== 1'b1 || unstable) begin
        fails++;
        $display("FAIL rand_hs[%0d]: rdy0=%b postv=%b postr=%b unstable=%b want 1 0 1 0",
                 n, rdy0, post_v, post_r, unstable);
      end
      if (lg) begin
        if (we)
          for (int i = 0; i < sz; i++)
            rmem[9'(a + 32'(i))] = 8'(wd >> (8 * i));
        tests++;
        if (nbeats != (cr ? 2 : 1) ||
            {b_addr[0], b_be[0], b_wd[0], b_we[0]} !==
            {a & ~32'h3, be0, w0, we}) begin
          fails++;
          $display("FAIL rand_beat0[%0d]: n=%0d a=%h be=%b wd=%h we=%b want %0d %h %b %h %b",
                   n, nbeats, b_addr[0], b_be[0], b_wd[0], b_we[0],
                   cr ? 2 : 1, a & ~32'h3, be0, w0, we);
        end
        if (cr) begin
          tests++;
          if ({b_addr[1], b_be[1], b_wd[1], b_we[1]} !==
              {(a & ~32'h3) + 32'd4, be1, w1, we}) begin
            fails++;
            $display("FAIL rand_beat1[%0d]: a=%h be=%b wd=%h we=%b want %h %b %h %b",
                     n, b_addr[1], b_be[1], b_wd[1], b_we[1],
                     (a & ~32'h3) + 32'd4, be1, w1, we);
          end
        end
        bad = 0;
        for (int k = 0; k < 8; k++)
          if (bmem[9'((a & ~32'h3) + 32'(k))] !== rmem[9'((a & ~32'h3) + 32'(k))])
            bad++;
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL rand_mem[%0d]: %0d bytes differ near %h want 0", n, bad, a);
        end
      end else begin
        tests++;
        if (nbeats != 0 || rsp_cyc != 1) begin
          fails++;
          $display("FAIL rand_fault[%0d]: n=%0d cyc=%0d want 0 1", n, nbeats, rsp_cyc);
        end
      end
      if (lg && !st) begin
        tests++;
        if (rsp_cyc != (cr ? 5 : 3)) begin
          fails++;
          $display("FAIL rand_latency[%0d]: got %0d want %0d", n, rsp_cyc, cr ? 5 : 3);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      bmem[i] = 8'($urandom);
      rmem[i] = bmem[i];
    end
    test_reset();
    test_lb();
    test_half();
    test_split_load();
    test_split_store();
    test_faults();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
